// File: rtl/fetch_pkg.sv
// fetch_pkg: shared widths, reset PC, NOP word and prefetch entry type for the fetch front end
package fetch_pkg;
   localparam int INSTR_W = 32;
   localparam int ADDR_W = 32;
   localparam logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000;
   localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;
   typedef struct packed {
      logic [INSTR_W-1:0] instr;
      logic [ADDR_W-1:0]  pc_plus4;
   } fetch_entry_t;
   function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:2], 2'b00};
   endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: imem request/response, decode output, redirect and error signals of the fetch front end
//   master: fetch_queue side; slave: memory/decode/redirect environment side
interface fetch_queue_if;
   import fetch_pkg::*;
   logic               imem_req_valid;
   logic               imem_req_ready;
   logic [ADDR_W-1:0]  imem_req_addr;
   logic               imem_rsp_valid;
   logic [INSTR_W-1:0] imem_rsp_data;
   logic               out_valid;
   logic               out_ready;
   logic [INSTR_W-1:0] out_instr;
   logic [ADDR_W-1:0]  out_pc_plus4;
   logic               redirect_valid;
   logic [ADDR_W-1:0]  redirect_target;
   logic               err_unexpected_rsp;
   modport master (
      output imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus4, err_unexpected_rsp,
      input  imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready, redirect_valid, redirect_target
   );
   modport slave (
      input  imem_req_valid, imem_req_addr, out_valid, out_instr, out_pc_plus4, err_unexpected_rsp,
      output imem_req_ready, imem_rsp_valid, imem_rsp_data, out_ready, redirect_valid, redirect_target
   );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: in-order FIFO with synchronous flush and occupancy count
//   clk/rst_n: clock, async active-low reset; flush: empties the FIFO, overriding push/pop
//   push/din: write; pop: read head (ignored when empty); dout: head; empty; count: occupancy
module sync_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 64,
   localparam int AW = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             empty,
   output logic [AW:0]      count
);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [AW:0] cnt_q, cnt_d;
   logic do_push, do_pop;
   assign empty = cnt_q == '0;
   assign count = cnt_q;
   assign dout = mem[rd_q];
   always_comb begin
      do_push = push && !flush;
      do_pop = pop && !empty && !flush;
      wr_d = flush ? '0 : wr_q + AW'(do_push);
      rd_d = flush ? '0 : rd_q + AW'(do_pop);
      cnt_d = flush ? '0 : cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_q <= '0;
         rd_q <= '0;
         cnt_q <= '0;
      end else begin
         wr_q <= wr_d;
         rd_q <= rd_d;
         cnt_q <= cnt_d;
      end
   always_ff @(posedge clk)
      if (do_push) mem[wr_q] <= din;
   assert property (@(posedge clk) disable iff (!rst_n)
      !(push && !flush && !pop && cnt_q == (AW+1)'(DEPTH)));
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC owner issuing imem word fetches into an in-order prefetch FIFO feeding decode
//   CLK/RST_N: clock, async active-low reset; bus: imem req/rsp, decode output, redirect, sticky error
module fetch_queue #(
   parameter int DEPTH = 4,
   parameter logic [fetch_pkg::ADDR_W-1:0] RESET_PC = fetch_pkg::RESET_PC
) (
   input logic           CLK,
   input logic           RST_N,
   fetch_queue_if.master bus
);
   import fetch_pkg::*;
   localparam int CW = $clog2(DEPTH) + 1;
   logic [ADDR_W-1:0] pc_q, pc_d, rsp_pc_q, rsp_pc_d, target;
   logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count;
   logic err_q, err_d, req_fire, rsp_ok, push, fifo_empty;
   fetch_entry_t din, head;
   // Credit: queued plus in-flight never exceeds DEPTH, so every kept response has a free slot
   assign bus.imem_req_valid = RST_N && !bus.redirect_valid &&
                               ({1'b0, count} + {1'b0, outst_q} < (CW+1)'(DEPTH));
   assign bus.imem_req_addr = pc_q;
   assign bus.out_valid = !fifo_empty;
   assign bus.out_instr = fifo_empty ? NOP_INSTR : head.instr;
   assign bus.out_pc_plus4 = fifo_empty ? '0 : head.pc_plus4;
   assign bus.err_unexpected_rsp = err_q;
   always_comb begin
      target = word_align(bus.redirect_target);
      req_fire = bus.imem_req_valid && bus.imem_req_ready;
      // A response with nothing outstanding is not ours: flag it, never count or push it
      rsp_ok = bus.imem_rsp_valid && outst_q != '0;
      push = rsp_ok && drop_q == '0 && !bus.redirect_valid;
      pc_d = bus.redirect_valid ? target : pc_q + (req_fire ? 32'd4 : 32'd0);
      rsp_pc_d = bus.redirect_valid ? target : push ? rsp_pc_q + 32'd4 : rsp_pc_q;
      outst_d = outst_q + CW'(req_fire) - CW'(rsp_ok);
      // On redirect every request still in flight after this cycle belongs to the old path
      drop_d = bus.redirect_valid ? outst_q - CW'(rsp_ok) : drop_q - CW'(rsp_ok && drop_q != '0);
      err_d = err_q || (bus.imem_rsp_valid && outst_q == '0);
      din.instr = bus.imem_rsp_data;
      din.pc_plus4 = rsp_pc_q + 32'd4;
   end
   always_ff @(posedge CLK or negedge RST_N)
      if (!RST_N) begin
         pc_q <= RESET_PC;
         rsp_pc_q <= RESET_PC;
         outst_q <= '0;
         drop_q <= '0;
         err_q <= 1'b0;
      end else begin
         pc_q <= pc_d;
         rsp_pc_q <= rsp_pc_d;
         outst_q <= outst_d;
         drop_q <= drop_d;
         err_q <= err_d;
      end
   sync_fifo #(.DEPTH(DEPTH), .WIDTH($bits(fetch_entry_t))) u_fifo (
      .clk(CLK),
      .rst_n(RST_N),
      .flush(bus.redirect_valid),
      .push(push),
      .pop(bus.out_ready && !bus.redirect_valid),
      .din(din),
      .dout(head),
      .empty(fifo_empty),
      .count(count)
   );
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed tests of fetch_queue against an in-order fetch-stream model
module tb_fetch_queue;
   import fetch_pkg::*;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   fetch_queue_if bus();
   fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (.CLK(clk), .RST_N(rst_n), .bus(bus));
   always #5 clk = ~clk;
   int checks = 0, passed = 0, cyc = 0, lat = 1, issued = 0, pops = 0;
   bit rand_ready = 1'b0;
   logic [31:0] mq_addr[$];
   int mq_due[$];
   logic [31:0] last_req = '0;
   logic [31:0] exp_addr = '0;
   bit prev_redir = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
   endtask

   // Model: decode must see the word stream from the current fetch address onward, instr = addr>>2
   always @(negedge clk) begin
      if (!rst_n) begin
         exp_addr = 32'h0;
         prev_redir = 1'b0;
      end else begin
         if (prev_redir) chk("valid_after_redirect", 32'(bus.out_valid), 32'd0);
         chk("addr_align", 32'(bus.imem_req_addr[1:0]), 32'd0);
         if (bus.redirect_valid) begin
            chk("no_req_on_redirect", 32'(bus.imem_req_valid), 32'd0);
            exp_addr = {bus.redirect_target[31:2], 2'b00};
         end else if (bus.out_valid && bus.out_ready) begin
            chk("out_pc_plus4", bus.out_pc_plus4, exp_addr + 32'd4);
            chk("out_instr", bus.out_instr, exp_addr >> 2);
            exp_addr += 32'd4;
            pops++;
         end
         prev_redir = bus.redirect_valid;
      end
   end

   task automatic cycle();
      @(negedge clk);
      if (rst_n && bus.imem_req_valid && bus.imem_req_ready) begin
         mq_addr.push_back(bus.imem_req_addr);
         mq_due.push_back(cyc + (rand_ready ? int'($urandom_range(1, 3)) : lat));
         last_req = bus.imem_req_addr;
         issued++;
      end
      @(posedge clk);
      #1;
      cyc++;
      if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
         bus.imem_rsp_valid = 1'b1;
         bus.imem_rsp_data = mq_addr[0] >> 2;
         void'(mq_addr.pop_front());
         void'(mq_due.pop_front());
      end else begin
         bus.imem_rsp_valid = 1'b0;
         bus.imem_rsp_data = '0;
      end
      if (rand_ready) bus.imem_req_ready = 1'($urandom_range(0, 1));
   endtask

   task automatic reset_dut();
      rst_n = 1'b0;
      bus.redirect_valid = 1'b0;
      bus.redirect_target = '0;
      bus.out_ready = 1'b0;
      bus.imem_req_ready = 1'b0;
      bus.imem_rsp_valid = 1'b0;
      bus.imem_rsp_data = '0;
      mq_addr.delete();
      mq_due.delete();
      rand_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
   endtask

   task automatic wait_valid(input string name);
      int w = 0;
      while (!bus.out_valid && w < 20) begin
         cycle();
         #1;
         w++;
      end
      chk(name, 32'(w < 20), 32'd1);
   endtask

   initial begin
      int iss0, p0, guard;
      reset_dut();
      chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("rst_req_addr", bus.imem_req_addr, RESET_PC);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_out_instr", bus.out_instr, 32'd0);
      chk("rst_out_pc_plus4", bus.out_pc_plus4, 32'd0);
      chk("rst_err", 32'(bus.err_unexpected_rsp), 32'd0);

      rst_n = 1'b1;
      lat = 1;
      bus.imem_req_ready = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      chk("zw_req_valid", 32'(bus.imem_req_valid), 32'd1);
      chk("zw_valid_c0", 32'(bus.out_valid), 32'd0);
      cycle();
      #1;
      chk("zw_valid_c1", 32'(bus.out_valid), 32'd0);
      cycle();
      #1;
      chk("zw_valid_c2", 32'(bus.out_valid), 32'd1);
      chk("zw_first_instr", bus.out_instr, 32'd0);
      chk("zw_first_pc4", bus.out_pc_plus4, 32'd4);
      for (int k = 1; k <= 8; k++) begin
         cycle();
         #1;
         chk("zw_stream_valid", 32'(bus.out_valid), 32'd1);
         chk("zw_stream_instr", bus.out_instr, 32'(k));
         chk("zw_stream_pc4", bus.out_pc_plus4, 32'(4 * k + 4));
      end

      reset_dut();
      rst_n = 1'b1;
      lat = 1;
      bus.imem_req_ready = 1'b1;
      iss0 = issued;
      repeat (10) cycle();
      #1;
      chk("stall_issued", 32'(issued - iss0), 32'd4);
      chk("stall_last_addr", last_req, 32'd12);
      chk("stall_req_valid", 32'(bus.imem_req_valid), 32'd0);
      chk("stall_head", bus.out_instr, 32'd0);
      bus.out_ready = 1'b1;
      p0 = pops;
      repeat (6) cycle();
      chk("stall_release_rate", 32'(pops - p0 >= 5), 32'd1);

      reset_dut();
      rst_n = 1'b1;
      lat = 3;
      bus.out_ready = 1'b1;
      bus.imem_req_ready = 1'b1;
      cycle();
      cycle();
      bus.imem_req_ready = 1'b0;
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 32'h0000_0103;
      #1;
      chk("redir_req_valid", 32'(bus.imem_req_valid), 32'd0);
      cycle();
      bus.redirect_valid = 1'b0;
      bus.imem_req_ready = 1'b1;
      #1;
      chk("redir_next_addr", bus.imem_req_addr, 32'h0000_0100);
      wait_valid("redir_timeout");
      chk("redir_pc4", bus.out_pc_plus4, 32'h0000_0104);
      chk("redir_instr", bus.out_instr, 32'h0000_0040);

      reset_dut();
      rst_n = 1'b1;
      lat = 2;
      bus.out_ready = 1'b1;
      bus.imem_req_ready = 1'b1;
      repeat (8) cycle();
      bus.redirect_valid = 1'b1;
      bus.redirect_target = 32'h0000_0200;
      #1;
      chk("same_cycle_rsp_present", 32'(bus.imem_rsp_valid), 32'd1);
      chk("same_cycle_pop_present", 32'(bus.out_valid), 32'd1);
      cycle();
      bus.redirect_valid = 1'b0;
      #1;
      chk("same_cycle_flushed", 32'(bus.out_valid), 32'd0);
      wait_valid("same_cycle_timeout");
      chk("same_cycle_pc4", bus.out_pc_plus4, 32'h0000_0204);
      chk("same_cycle_instr", bus.out_instr, 32'h0000_0080);

      reset_dut();
      rst_n = 1'b1;
      rand_ready = 1'b1;
      p0 = pops;
      guard = 0;
      while (pops - p0 < 200 && guard < 3000) begin
         bus.out_ready = 1'($urandom_range(0, 1));
         bus.redirect_valid = (guard == 50 || guard == 51);
         bus.redirect_target = (guard == 50) ? 32'h0000_0400 : 32'h0000_0802;
         cycle();
         guard++;
      end
      bus.redirect_valid = 1'b0;
      chk("random_200_done", 32'(pops - p0 >= 200), 32'd1);

      reset_dut();
      rst_n = 1'b1;
      lat = 1;
      rand_ready = 1'b0;
      bus.imem_req_ready = 1'b1;
      repeat (10) cycle();
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data = 32'hdead_beef;
      #1;
      chk("spur_err_before", 32'(bus.err_unexpected_rsp), 32'd0);
      cycle();
      #1;
      chk("spur_err_set", 32'(bus.err_unexpected_rsp), 32'd1);
      chk("spur_head_kept", bus.out_instr, 32'd0);
      repeat (3) cycle();
      chk("spur_err_sticky", 32'(bus.err_unexpected_rsp), 32'd1);
      bus.out_ready = 1'b1;
      p0 = pops;
      repeat (8) cycle();
      chk("spur_no_extra_entry", 32'(pops - p0 >= 4), 32'd1);
      chk("spur_err_still", 32'(bus.err_unexpected_rsp), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("async_rst_err", 32'(bus.err_unexpected_rsp), 32'd0);
      chk("async_rst_valid", 32'(bus.out_valid), 32'd0);
      chk("async_rst_addr", bus.imem_req_addr, 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end
endmodule
